// File: rtl/ysyx_22040895_muldiv_seq.sv
// Iterative RV64M MUL/DIV/DIVU/REM/REMU sequencer that borrows the shared 64-bit ALU.
// Latency: 64 granted LOOP cycles plus one each for NEGA/NEGB/FIX; divide-by-zero and reserved ops take 1 cycle. State holds while the ALU is not granted, and valid_o holds until ready_i.
module ysyx_22040895_muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  op_i,
    input  logic [63:0] src1_i,
    input  logic [63:0] src2_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] result_o,
    input  logic        flush_i,
    output logic        alu_req_o,
    input  logic        alu_gnt_i,
    output logic [3:0]  aluop_o,
    output logic [63:0] op1_o,
    output logic [63:0] op2_o,
    input  logic [63:0] alu_result_i,
    input  logic        alu_ltu_i
);
    typedef enum logic [2:0] {S_IDLE, S_NEGA, S_NEGB, S_LOOP, S_FIX, S_DONE} state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        sa_q, sa_d, sb_q, sb_d;
    // acc: MUL accumulator / remainder; x: multiplicand / quotient; y: multiplier / divisor
    logic [63:0] acc_q, acc_d, x_q, x_d, y_q, y_d, res_q, res_d;

    logic        in_signed, in_sa, in_sb, in_reserved;
    logic        is_mul, take, fix_needed;
    logic [63:0] shifted, div_rem_nxt, div_quo_nxt;

    assign in_signed   = op_i[2] & ~op_i[0];
    assign in_sa       = in_signed & src1_i[63];
    assign in_sb       = in_signed & src2_i[63];
    assign in_reserved = ~op_i[2] & (op_i[1:0] != 2'b00);

    assign is_mul      = (op_q == 3'b000);
    assign shifted     = {acc_q[62:0], x_q[63]};
    // A set rem[63] means the true 65-bit shifted value beats any divisor.
    assign take        = acc_q[63] | ~alu_ltu_i;
    assign div_rem_nxt = take ? alu_result_i : shifted;
    assign div_quo_nxt = {x_q[62:0], take};
    assign fix_needed  = op_q[1] ? sa_q : (sa_q ^ sb_q);

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = res_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        acc_d     = acc_q;
        x_d       = x_q;
        y_d       = y_q;
        res_d     = res_q;
        alu_req_o = 1'b0;
        aluop_o   = ALU_ADD;
        op1_o     = 64'd0;
        op2_o     = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    cnt_d = 6'd0;
                    op_d  = op_i;
                    sa_d  = in_sa;
                    sb_d  = in_sb;
                    acc_d = 64'd0;
                    x_d   = src1_i;
                    y_d   = src2_i;
                    if (in_reserved) begin
                        res_d   = 64'd0;
                        state_d = S_DONE;
                    end else if (op_i[2] && src2_i == 64'd0) begin
                        res_d   = op_i[1] ? src1_i : {64{1'b1}};
                        state_d = S_DONE;
                    end else if (in_sa) begin
                        state_d = S_NEGA;
                    end else if (in_sb) begin
                        state_d = S_NEGB;
                    end else begin
                        state_d = S_LOOP;
                    end
                end
            end
            S_NEGA: begin
                alu_req_o = 1'b1;
                aluop_o   = ALU_SUB;
                op2_o     = x_q;
                if (alu_gnt_i) begin
                    x_d     = alu_result_i;
                    state_d = sb_q ? S_NEGB : S_LOOP;
                end
            end
            S_NEGB: begin
                alu_req_o = 1'b1;
                aluop_o   = ALU_SUB;
                op2_o     = y_q;
                if (alu_gnt_i) begin
                    y_d     = alu_result_i;
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                alu_req_o = 1'b1;
                if (is_mul) begin
                    aluop_o = ALU_ADD;
                    op1_o   = acc_q;
                    op2_o   = y_q[0] ? x_q : 64'd0;
                end else begin
                    aluop_o = ALU_SUB;
                    op1_o   = shifted;
                    op2_o   = y_q;
                end
                if (alu_gnt_i) begin
                    cnt_d = cnt_q + 6'd1;
                    if (is_mul) begin
                        acc_d = alu_result_i;
                        x_d   = {x_q[62:0], 1'b0};
                        y_d   = {1'b0, y_q[63:1]};
                    end else begin
                        acc_d = div_rem_nxt;
                        x_d   = div_quo_nxt;
                    end
                    if (cnt_q == 6'd63) begin
                        if (is_mul) begin
                            res_d   = alu_result_i;
                            state_d = S_DONE;
                        end else if (fix_needed) begin
                            state_d = S_FIX;
                        end else begin
                            res_d   = op_q[1] ? div_rem_nxt : div_quo_nxt;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_FIX: begin
                alu_req_o = 1'b1;
                aluop_o   = ALU_SUB;
                op2_o     = op_q[1] ? acc_q : x_q;
                if (alu_gnt_i) begin
                    res_d   = alu_result_i;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 3'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= 64'd0;
            x_q     <= 64'd0;
            y_q     <= 64'd0;
            res_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22040895_muldiv_seq.sv
// Directed bench for the MUL/DIV sequencer, with a behavioural model of the shared ALU.
module tb_ysyx_22040895_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, valid_o, ready_i, flush_i;
    logic [2:0]  op_i;
    logic [63:0] src1_i, src2_i, result_o;
    logic        alu_req_o, alu_gnt_i, alu_ltu_i;
    logic [3:0]  aluop_o;
    logic [63:0] op1_o, op2_o, alu_result_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [2:0] OP_MUL = 3'b000, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;

    assign alu_result_i = (aluop_o == 4'b0001) ? (op1_o - op2_o) : (op1_o + op2_o);
    assign alu_ltu_i    = (op1_o < op2_o);

    ysyx_22040895_muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .src1_i(src1_i), .src2_i(src2_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .flush_i(flush_i), .alu_req_o(alu_req_o), .alu_gnt_i(alu_gnt_i),
        .aluop_o(aluop_o), .op1_o(op1_o), .op2_o(op2_o), .alu_result_i(alu_result_i),
        .alu_ltu_i(alu_ltu_i)
    );

    // lat = clock edges from the accept edge (inclusive) until valid_o is visible
    task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input bit toggle, output logic [63:0] res, output int lat,
                         output int grants, output bit seen);
        int w = 0;
        while (!ready_o && w < 20) begin @(posedge clk); #1; w++; end
        op_i = op; src1_i = a; src2_i = b; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1; grants = 0;
        while (!valid_o && lat < 400) begin
            alu_gnt_i = toggle ? ~alu_gnt_i : 1'b1;
            @(negedge clk);
            if (alu_req_o && alu_gnt_i) grants++;
            @(posedge clk); #1;
            lat++;
        end
        alu_gnt_i = 1'b1;
        seen = valid_o;
        res  = result_o;
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total_cnt++; if (ready_o !== 1'b1 || valid_o !== 1'b0) $display("FAIL reset_hs ready=%b valid=%b expected 1 0", ready_o, valid_o); else pass_cnt++;
        total_cnt++; if (result_o !== 64'd0) $display("FAIL reset_result got %h expected 0", result_o); else pass_cnt++;
        total_cnt++; if (alu_req_o !== 1'b0 || aluop_o !== 4'd0 || op1_o !== 64'd0 || op2_o !== 64'd0)
            $display("FAIL reset_alu req=%b op=%h op1=%h op2=%h expected all 0", alu_req_o, aluop_o, op1_o, op2_o); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [63:0] r; int lat, g; bit s;
        do_op(OP_MUL, 64'd3, 64'd5, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'd15) $display("FAIL mul_3x5 got %h expected %h", r, 64'd15); else pass_cnt++;
        total_cnt++; if (lat !== 65) $display("FAIL mul_latency got %0d expected 65", lat); else pass_cnt++;
        consume();
        total_cnt++; if (ready_o !== 1'b1 || valid_o !== 1'b0) $display("FAIL mul_handoff ready=%b valid=%b expected 1 0", ready_o, valid_o); else pass_cnt++;
        do_op(OP_MUL, ONES, 64'd2, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL mul_ones_x2 got %h expected fffffffffffffffe", r); else pass_cnt++;
        consume();
    endtask

    task automatic test_divu();
        logic [63:0] r; int lat, g; bit s;
        do_op(OP_DIVU, 64'd100, 64'd7, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'd14) $display("FAIL divu_100_7 got %h expected %h", r, 64'd14); else pass_cnt++;
        total_cnt++; if (lat !== 65) $display("FAIL divu_latency got %0d expected 65", lat); else pass_cnt++;
        consume();
        do_op(OP_REMU, 64'd100, 64'd7, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'd2) $display("FAIL remu_100_7 got %h expected %h", r, 64'd2); else pass_cnt++;
        total_cnt++; if (lat !== 65) $display("FAIL remu_latency got %0d expected 65", lat); else pass_cnt++;
        consume();
    endtask

    task automatic test_div_signed();
        logic [63:0] r; int lat, g; bit s;
        // -7/2: NEGA + 64 LOOP + FIX
        do_op(OP_DIV, -64'sd7, 64'd2, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_m7_2 got %h expected fffffffffffffffd", r); else pass_cnt++;
        total_cnt++; if (lat !== 67) $display("FAIL div_m7_2_latency got %0d expected 67", lat); else pass_cnt++;
        consume();
        do_op(OP_REM, -64'sd7, 64'd2, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== ONES) $display("FAIL rem_m7_2 got %h expected %h", r, ONES); else pass_cnt++;
        consume();
        do_op(OP_DIV, 64'd7, -64'sd2, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_7_m2 got %h expected fffffffffffffffd", r); else pass_cnt++;
        total_cnt++; if (lat !== 67) $display("FAIL div_7_m2_latency got %0d expected 67", lat); else pass_cnt++;
        consume();
        // MIN / -1: NEGA + NEGB, no quotient fix
        do_op(OP_DIV, MINV, ONES, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== MINV) $display("FAIL div_min_m1 got %h expected %h", r, MINV); else pass_cnt++;
        total_cnt++; if (lat !== 67) $display("FAIL div_min_m1_latency got %0d expected 67", lat); else pass_cnt++;
        consume();
        do_op(OP_REM, MINV, ONES, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'd0) $display("FAIL rem_min_m1 got %h expected 0", r); else pass_cnt++;
        consume();
    endtask

    task automatic test_div_zero();
        logic [63:0] r; int lat, g; bit s;
        do_op(OP_DIVU, 64'd42, 64'd0, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== ONES) $display("FAIL divu_by0 got %h expected %h", r, ONES); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL divu_by0_latency got %0d expected 1", lat); else pass_cnt++;
        consume();
        do_op(OP_REM, -64'sd5, 64'd0, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'hFFFF_FFFF_FFFF_FFFB) $display("FAIL rem_by0 got %h expected fffffffffffffffb", r); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL rem_by0_latency got %0d expected 1", lat); else pass_cnt++;
        consume();
        do_op(3'b010, 64'd9, 64'd3, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'd0 || lat !== 1) $display("FAIL reserved_op got %h lat %0d expected 0 lat 1", r, lat); else pass_cnt++;
        consume();
    endtask

    task automatic test_rem63();
        logic [63:0] r; int lat, g; bit s;
        do_op(OP_DIVU, ONES, 64'h8000_0000_0000_0001, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'd1) $display("FAIL divu_big got %h expected 1", r); else pass_cnt++;
        consume();
        do_op(OP_REMU, ONES, 64'h8000_0000_0000_0001, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'h7FFF_FFFF_FFFF_FFFE) $display("FAIL remu_big got %h expected 7ffffffffffffffe", r); else pass_cnt++;
        consume();
    endtask

    task automatic test_gnt_toggle();
        logic [63:0] r; int lat, g; bit s;
        do_op(OP_MUL, 64'd3, 64'd5, 1'b1, r, lat, g, s);
        total_cnt++; if (!s || r !== 64'd15) $display("FAIL tog_mul seen=%b got %h expected 15", s, r); else pass_cnt++;
        total_cnt++; if (g !== 64) $display("FAIL tog_mul_grants got %0d expected 64", g); else pass_cnt++;
        consume();
        do_op(OP_DIVU, 64'd100, 64'd7, 1'b1, r, lat, g, s);
        total_cnt++; if (!s || r !== 64'd14) $display("FAIL tog_divu seen=%b got %h expected 14", s, r); else pass_cnt++;
        total_cnt++; if (g !== 64) $display("FAIL tog_divu_grants got %0d expected 64", g); else pass_cnt++;
        consume();
        do_op(OP_DIV, -64'sd7, 64'd2, 1'b1, r, lat, g, s);
        total_cnt++; if (!s || r !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL tog_div seen=%b got %h expected fffffffffffffffd", s, r); else pass_cnt++;
        total_cnt++; if (g !== 66) $display("FAIL tog_div_grants got %0d expected 66", g); else pass_cnt++;
        consume();
    endtask

    task automatic test_flush();
        logic [63:0] r; int lat, g, n; bit s, saw;
        op_i = OP_MUL; src1_i = 64'd11; src2_i = 64'd13; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        g = 0; n = 0;
        while (g < 30 && n < 200) begin
            @(negedge clk);
            if (alu_req_o && alu_gnt_i) g++;
            @(posedge clk); #1;
            n++;
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        total_cnt++; if (ready_o !== 1'b1 || valid_o !== 1'b0) $display("FAIL flush_idle ready=%b valid=%b expected 1 0", ready_o, valid_o); else pass_cnt++;
        saw = 1'b0;
        for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (valid_o) saw = 1'b1; end
        total_cnt++; if (saw !== 1'b0) $display("FAIL flush_no_valid saw=%b expected 0", saw); else pass_cnt++;
        do_op(OP_MUL, 64'd6, 64'd7, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'd42 || lat !== 65) $display("FAIL after_flush got %h lat %0d expected 2a lat 65", r, lat); else pass_cnt++;
        consume();
    endtask

    task automatic test_reset_mid();
        bit saw;
        op_i = OP_DIVU; src1_i = 64'd1000; src2_i = 64'd3; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2;
        total_cnt++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 64'd0)
            $display("FAIL midrst_hs ready=%b valid=%b result=%h expected 1 0 0", ready_o, valid_o, result_o); else pass_cnt++;
        total_cnt++; if (alu_req_o !== 1'b0 || aluop_o !== 4'd0 || op1_o !== 64'd0 || op2_o !== 64'd0)
            $display("FAIL midrst_alu req=%b op=%h op1=%h op2=%h expected all 0", alu_req_o, aluop_o, op1_o, op2_o); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (valid_o) saw = 1'b1; end
        total_cnt++; if (saw !== 1'b0) $display("FAIL midrst_no_valid saw=%b expected 0", saw); else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        logic [63:0] r; int lat, g; bit s;
        do_op(OP_MUL, 64'h1234, 64'h10, 1'b0, r, lat, g, s);
        total_cnt++; if (r !== 64'h12340) $display("FAIL bp_result got %h expected 12340", r); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total_cnt++; if (valid_o !== 1'b1 || result_o !== 64'h12340 || ready_o !== 1'b0)
                $display("FAIL bp_hold cycle %0d valid=%b ready=%b result=%h expected 1 0 12340", i, valid_o, ready_o, result_o); else pass_cnt++;
        end
        consume();
        total_cnt++; if (ready_o !== 1'b1 || valid_o !== 1'b0) $display("FAIL bp_release ready=%b valid=%b expected 1 0", ready_o, valid_o); else pass_cnt++;
    endtask

    initial begin
        valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; alu_gnt_i = 1'b1;
        op_i = 3'd0; src1_i = 64'd0; src2_i = 64'd0;
        test_reset();
        test_mul();
        test_divu();
        test_div_signed();
        test_div_zero();
        test_rem63();
        test_gnt_toggle();
        test_flush();
        test_reset_mid();
        test_back_pressure();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
